// File: rtl/data_mem_ctrl.sv
// Data-memory access unit: word-organised synchronous RAM with byte-lane stores,
// aligned/extended loads, a load stall (busy) and illegal-access fault pulses.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMRd,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  output logic [31:0] DataRd,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata;
  logic [29:0] widx;
  logic [1:0]  lane;
  logic        in_range;
  logic        ctrl_ok;
  logic        align_ok;
  logic        legal;
  logic        sample;
  logic        ld_go;
  logic        st_go;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  ld_ctrl;
  logic [1:0]  ld_lane;
  logic [31:0] fmt;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        st_done_q;
  logic        fault_q;

  // BASE_ADDR is assumed word aligned, so the word index comes from the upper bits alone
  assign widx     = Address[31:2] - BASE_ADDR[31:2];
  assign lane     = Address[1:0];
  assign in_range = (Address >= BASE_ADDR) && (widx < 30'(DEPTH_WORDS));

  always_comb begin
    ctrl_ok  = 1'b0;
    align_ok = 1'b0;
    case (DMCtrl)
      3'b000: begin ctrl_ok = 1'b1;  align_ok = 1'b1;             end
      3'b001: begin ctrl_ok = 1'b1;  align_ok = ~lane[0];         end
      3'b010: begin ctrl_ok = 1'b1;  align_ok = (lane == 2'b00);  end
      3'b100: begin ctrl_ok = ~DMWr; align_ok = 1'b1;             end
      3'b101: begin ctrl_ok = ~DMWr; align_ok = ~lane[0];         end
      default: begin ctrl_ok = 1'b0; align_ok = 1'b0;             end
    endcase
  end

  assign legal  = ctrl_ok & align_ok & in_range & ~(DMRd & DMWr);
  // RD_DONE doubles as IDLE for request sampling, allowing back-to-back loads
  assign sample = ~rst & ((state == IDLE) | (state == RD_DONE));
  assign ld_go  = sample & DMRd & legal;
  assign st_go  = sample & DMWr & legal;
  assign bad    = sample & (DMRd | DMWr) & ~legal;

  always_comb begin
    be    = '0;
    wdata = DataWr;
    case (DMCtrl[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{DataWr[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{DataWr[15:0]}};
      end
      default: begin
        be    = '1;
        wdata = DataWr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_go) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (ld_go) rdata <= mem[widx[AW-1:0]];
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE, RD_DONE: state_nx = ld_go ? RD_WAIT : IDLE;
      RD_WAIT:       state_nx = RD_DONE;
      default:       state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (ld_lane)
      2'd0:    bsel = rdata[7:0];
      2'd1:    bsel = rdata[15:8];
      2'd2:    bsel = rdata[23:16];
      default: bsel = rdata[31:24];
    endcase
    hsel = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    case (ld_ctrl)
      3'b000:  fmt = {{24{bsel[7]}}, bsel};
      3'b100:  fmt = {24'h0, bsel};
      3'b001:  fmt = {{16{hsel[15]}}, hsel};
      3'b101:  fmt = {16'h0, hsel};
      default: fmt = rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_go) begin
      ld_ctrl <= DMCtrl;
      ld_lane <= lane;
    end
    if (rst) begin
      state     <= IDLE;
      DataRd    <= '0;
      st_done_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      st_done_q <= st_go;
      fault_q   <= bad;
      if (state == RD_WAIT) DataRd <= fmt;
    end
  end

  assign busy  = ld_go | (state == RD_WAIT);
  assign done  = (state == RD_DONE) | st_done_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: byte-array reference model, queued expected
// completions, and a negedge monitor that checks each done/fault pulse.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned REGION = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DMRd = 1'b0, DMWr = 1'b0;
  logic [2:0]  DMCtrl = '0;
  logic [31:0] Address = '0, DataWr = '0;
  logic [31:0] DataRd;
  logic        busy, done, fault;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .DMRd(DMRd), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .Address(Address), .DataWr(DataWr), .DataRd(DataRd),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [31:0] rd;
    int unsigned at;
  } exp_t;

  exp_t         sbq[$];
  byte unsigned mm [int unsigned];
  logic [31:0]  last_rd = '0;
  int unsigned  cyc = 0;
  int           n_chk = 0, n_fail = 0;
  bit           mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] ctrl,
                                  input logic [31:0] a);
    int unsigned sz = acc_size(ctrl);
    if (rd && wr) return 1'b0;
    if (sz == 0) return 1'b0;
    if (ctrl[2] && (wr || sz == 4)) return 1'b0;
    if (a % sz != 0) return 1'b0;
    if (a < BASE) return 1'b0;
    if ((a - BASE) / 4 >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] ctrl, input logic [31:0] a);
    int unsigned sz = acc_size(ctrl);
    longint v = 0;
    for (int unsigned i = 0; i < sz; i++) v += longint'(mm[a + i]) << (8 * i);
    if (!ctrl[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return 32'(v);
  endfunction

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      DMRd = 1'b0; DMWr = 1'b0;
      @(negedge clk);
      chk("busy_idle", 32'(busy), 0);
      @(posedge clk); #1;
    end
  endtask

  // Drives one request for one cycle; for a legal load also covers the wait cycle
  // with junk inputs, returning at the start of the RD_DONE cycle.
  task automatic issue(input bit rd, input bit wr, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit ok = is_legal(rd, wr, ctrl, a);
    DMRd = rd; DMWr = wr; DMCtrl = ctrl; Address = a; DataWr = d;
    if (!ok || wr) begin
      if (ok) for (int unsigned i = 0; i < acc_size(ctrl); i++) mm[a + i] = 8'(d >> (8 * i));
      e = '{!ok, last_rd, cyc + 1};
      sbq.push_back(e);
      @(negedge clk);
      chk("busy_nonload", 32'(busy), 0);
      @(posedge clk); #1;
    end else begin
      last_rd = model_load(ctrl, a);
      e = '{1'b0, last_rd, cyc + 2};
      sbq.push_back(e);
      @(negedge clk);
      chk("busy_load_n", 32'(busy), 1);
      @(posedge clk); #1;
      DMRd = 1'($urandom); DMWr = 1'($urandom); DMCtrl = 3'($urandom);
      Address = $urandom_range(0, REGION - 1); DataWr = $urandom;
      @(negedge clk);
      chk("busy_load_n1", 32'(busy), 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic ld_lit(input string nm, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] exp);
    issue(1'b1, 1'b0, ctrl, a, '0);
    idle(1);
    chk(nm, DataRd, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && mon_en) begin
      chk("done_fault_excl", 32'(done & fault), 0);
      if (done || fault) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", {30'd0, done, fault}, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_cycle", cyc, e.at);
          chk("out_kind_fault", 32'(fault), 32'(e.is_fault));
          chk("out_datard", DataRd, e.rd);
        end
      end else if (sbq.size() > 0 && sbq[0].at <= cyc) begin
        void'(sbq.pop_front());
        chk("missing_out", 32'(done | fault), 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned r, sz;
    logic [2:0]  ctrl;
    logic [31:0] a;
    bit          rd, wr;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_datard", DataRd, 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_fault", 32'(fault), 0);
    chk("post_rst_datard", DataRd, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int unsigned w = 0; w < REGION / 4; w++) issue(1'b0, 1'b1, 3'b010, BASE + 4 * w, $urandom);

    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    ld_lit("lw_dead", 3'b010, 32'h10, 32'hDEAD_BEEF);
    ld_lit("lb_13", 3'b000, 32'h13, 32'hFFFF_FFDE);
    ld_lit("lbu_13", 3'b100, 32'h13, 32'h0000_00DE);
    ld_lit("lh_12", 3'b001, 32'h12, 32'hFFFF_DEAD);
    ld_lit("lhu_10", 3'b101, 32'h10, 32'h0000_BEEF);
    issue(1'b0, 1'b1, 3'b000, 32'h11, 32'hAAAA_AA55);
    issue(1'b0, 1'b1, 3'b001, 32'h12, 32'h9999_1234);
    ld_lit("lw_merge", 3'b010, 32'h10, 32'h1234_55EF);

    issue(1'b1, 1'b0, 3'b010, 32'h12, '0);
    issue(1'b0, 1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 3'b011, 32'h10, '0);
    issue(1'b0, 1'b1, 3'b010, DEPTH * 4, 32'hFFFF_FFFF);
    issue(1'b1, 1'b1, 3'b010, 32'h10, 32'h0);
    idle(1);
    chk("fault_datard_kept", DataRd, 32'h1234_55EF);
    ld_lit("lw_after_faults", 3'b010, 32'h10, 32'h1234_55EF);

    DMRd = 1'b1; DMWr = 1'b0; DMCtrl = 3'b010; Address = 32'h20;
    @(negedge clk);
    chk("abort_busy_n", 32'(busy), 1);
    @(posedge clk); #1;
    DMRd = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_datard", DataRd, 0);
    last_rd = '0;
    @(posedge clk); #1;
    ld_lit("lw_after_abort", 3'b010, 32'h10, 32'h1234_55EF);

    issue(1'b1, 1'b0, 3'b010, 32'h10, '0);
    issue(1'b1, 1'b0, 3'b000, 32'h13, '0);
    issue(1'b1, 1'b0, 3'b101, 32'h12, '0);
    issue(1'b0, 1'b1, 3'b010, 32'h24, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 3'b010, 32'h24, '0);
    idle(1);
    chk("st_then_ld", DataRd, 32'hCAFE_F00D);

    for (int unsigned n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      rd = (r <= 3) || (r == 8);
      wr = (r >= 4 && r <= 8);
      if (r == 9) begin
        idle(1);
        continue;
      end
      if ($urandom_range(0, 6) == 0) ctrl = 3'($urandom);
      else begin
        case ($urandom_range(0, 4))
          0: ctrl = 3'b000;
          1: ctrl = 3'b001;
          2: ctrl = 3'b010;
          3: ctrl = 3'b100;
          default: ctrl = 3'b101;
        endcase
      end
      sz = acc_size(ctrl);
      a  = $urandom_range(0, REGION - 1);
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
      if ($urandom_range(0, 14) == 0) a = ($urandom_range(0, 1) == 0) ? DEPTH * 4 + a : 32'hFFFF_FFFC;
      issue(rd, wr, ctrl, BASE + a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    chk("queue_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
